rx_meta_packet_aligner: RTL
===========================

# rx_meta_packet_aligner

Receive-side stage directly downstream of packet classification on the RoCEv2 output. It buffers the per-packet metadata pulses emitted by the classifier in a small FIFO and re-attaches each metadata word to its packet, holding it stable on every beat of that packet. It also checks the received byte count against the carried size and reports overflow and length errors. Its output feeds the RDMA receive engine.

## Interface
- METADATA_WIDTH, 263, metadata word width
- AXIS_DATA_WIDTH, 512, stream data width
- AXIS_KEEP_WIDTH, 64, byte-enable width (AXIS_DATA_WIDTH/8)
- AXIS_USER_WIDTH, 16, packet size field width
- META_FIFO_DEPTH, 8, metadata FIFO entries; power of 2, at least 2

- axis_aclk  in  1  single clock
- axis_rstn  in  1  reset, synchronous, active-low
- metadata_in  in  METADATA_WIDTH  metadata word from the classifier
- metadata_in_valid  in  1  one-cycle write pulse; there is no ready
- s_axis_tvalid / s_axis_tready  in / out  1  input packet handshake
- s_axis_tdata  in  AXIS_DATA_WIDTH  packet data
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  byte enables
- s_axis_tuser_size  in  AXIS_USER_WIDTH  packet length in bytes, valid on SOP
- s_axis_tlast  in  1  end of packet
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake
- m_axis_tdata, m_axis_tkeep, m_axis_tlast  out  as input  registered copy of input
- m_axis_tuser_size  out  AXIS_USER_WIDTH  size latched at SOP, held for the whole packet
- m_axis_tuser_metadata  out  METADATA_WIDTH  metadata paired with the packet, held for the whole packet
- m_axis_len_err  out  1  valid on the tlast beat: received bytes != latched size
- meta_overflow_cnt  out  16  saturating count of dropped metadata writes
- pkt_cnt  out  32  wrapping count of packets completed at the output
- err_sticky  out  2  bit0 metadata overflow, bit1 length error; cleared only by reset

## Operation
- Metadata FIFO:
  - A write on metadata_in_valid is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped, meta_overflow_cnt increments (saturating at 0xFFFF), and err_sticky[0] sets.
  - A write becomes visible at the FIFO head on the next cycle.
- FSM states:
  - IDLE: waiting for SOP. An SOP beat is accepted only when the FIFO is non-empty. On acceptance the block latches the FIFO head and s_axis_tuser_size, pops the FIFO, and moves to IN_PKT. If tlast is set on the same beat, it stays in IDLE.
  - IN_PKT: passes beats through. A beat with tlast returns the FSM to IDLE.
- s_axis_tready = (!m_axis_tvalid || m_axis_tready) && (state == IN_PKT || fifo_not_empty).
  - A SOP with an empty FIFO stalls; the packet is never dropped.
- Byte count:
  - 16-bit accumulator; each accepted beat adds popcount(s_axis_tkeep), using modulo 2^16 arithmetic.
  - The accumulator is cleared at SOP, so the SOP beat loads its own popcount.
  - On the tlast beat, m_axis_len_err = (final sum != latched size). Any mismatch also sets err_sticky[1].
  - m_axis_len_err is 0 on all non-tlast beats.
- pkt_cnt increments on each output handshake with m_axis_tlast = 1, and wraps to 0 after 0xFFFFFFFF.

## Timing
- Single output register stage. An input beat accepted at cycle N appears at the output at cycle N+1.
- Full throughput of one beat per cycle while m_axis_tready stays high and metadata is available.
- Output hold rule: while m_axis_tvalid = 1 and m_axis_tready = 0, every m_axis_* output holds its value.
- Minimum metadata-to-data latency: metadata pulsed at cycle N allows SOP acceptance at cycle N+1 at the earliest.
- Reset values: m_axis_tvalid 0; m_axis_tdata, tkeep, tlast, tuser_size, tuser_metadata 0; m_axis_len_err 0; FIFO empty; state IDLE; all counters and err_sticky 0. s_axis_tready is 0 while reset is asserted.
- Reset asserted mid-packet:
  - All state clears: FIFO empty, FSM in IDLE.
  - The next beat accepted after reset is treated as SOP.
  - Residual beats of the interrupted packet are the upstream's responsibility.

## Test plan
- Metadata M0 pulsed, then a 3-beat packet with all keeps set (tkeep all ones) and size 192 → output has 3 beats, each carrying M0 and size 192; len_err 0; pkt_cnt 1; first output beat appears 1 cycle after the first input beat.
- SOP presented with the FIFO empty for 5 cycles, then metadata pulsed → s_axis_tready stays 0 for those cycles; the packet is accepted 1 cycle after the pulse.
- 9 metadata pulses with no packets and depth 8 → meta_overflow_cnt = 1, err_sticky = 2'b01; the 8 stored words are emitted in order with the next 8 packets.
- 2-beat packet with size 100 and tkeep popcounts 64 + 32 → len_err = 1 on the tlast beat; err_sticky[1] sets.
- Random m_axis_tready toggling over 50 mixed 1–4 beat packets → no data loss or duplication; metadata order preserved; outputs stable while stalled.
- Reset asserted mid-packet with 3 FIFO entries → FIFO empties, outputs return to reset values, and the next accepted beat is treated as SOP.

Source files
------------

// File: rtl/rx_meta_packet_aligner_if.sv
// Packet-side bus of the RoCEv2 receive metadata aligner: classifier metadata,
// input stream and output stream. The aligner uses the slave view.
interface rx_meta_packet_aligner_if #(
  parameter int METADATA_WIDTH  = 263,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int AXIS_USER_WIDTH = 16
);
  logic [METADATA_WIDTH-1:0]  metadata_in;
  logic                       metadata_in_valid;

  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser_size;
  logic                       s_axis_tlast;

  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep;
  logic                       m_axis_tlast;
  logic [AXIS_USER_WIDTH-1:0] m_axis_tuser_size;
  logic [METADATA_WIDTH-1:0]  m_axis_tuser_metadata;
  logic                       m_axis_len_err;

  modport master (
    output metadata_in, metadata_in_valid,
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tuser_size, s_axis_tlast,
    input  s_axis_tready,
    output m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    input  m_axis_tuser_size, m_axis_tuser_metadata, m_axis_len_err
  );

  modport slave (
    input  metadata_in, metadata_in_valid,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tuser_size, s_axis_tlast,
    output s_axis_tready,
    input  m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    output m_axis_tuser_size, m_axis_tuser_metadata, m_axis_len_err
  );
endinterface

// File: rtl/rx_meta_packet_aligner.sv
// Re-attaches classifier metadata (buffered in a small FIFO) to each received
// packet, with one output register stage, length checking and error counters.
module rx_meta_packet_aligner #(
  parameter int METADATA_WIDTH  = 263,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int AXIS_USER_WIDTH = 16,
  parameter int META_FIFO_DEPTH = 8
) (
  input  logic                        axis_aclk,
  input  logic                        axis_rstn,
  rx_meta_packet_aligner_if.slave     bus,
  output logic [15:0]                 meta_overflow_cnt,
  output logic [31:0]                 pkt_cnt,
  output logic [1:0]                  err_sticky
);
  localparam int PTR_W = $clog2(META_FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

  state_t                      state_reg;
  logic [METADATA_WIDTH-1:0]   fifo_mem [META_FIFO_DEPTH];
  logic [PTR_W:0]              wr_ptr_reg, rd_ptr_reg;
  logic [15:0]                 byte_acc_reg;
  logic [15:0]                 ovf_cnt_reg;
  logic [31:0]                 pkt_cnt_reg;
  logic [1:0]                  err_sticky_reg;

  logic                        m_valid_reg, m_last_reg, m_len_err_reg;
  logic [AXIS_DATA_WIDTH-1:0]  m_data_reg;
  logic [AXIS_KEEP_WIDTH-1:0]  m_keep_reg;
  logic [AXIS_USER_WIDTH-1:0]  m_size_reg;
  logic [METADATA_WIDTH-1:0]   m_meta_reg;

  logic                        fifo_empty, fifo_full, fifo_push, fifo_pop, meta_drop;
  logic                        s_ready, in_fire, sop, len_mismatch;
  logic [METADATA_WIDTH-1:0]   fifo_head;
  logic [AXIS_USER_WIDTH-1:0]  size_ref;
  logic [15:0]                 byte_sum_next;
  logic [15:0]                 keep_sum [AXIS_KEEP_WIDTH+1];

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  // Small enough for distributed RAM; the asynchronous read makes a write
  // usable as the head on the very next cycle.
  assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  assign s_ready   = axis_rstn && (!m_valid_reg || bus.m_axis_tready) &&
                     (state_reg == ST_IN_PKT || !fifo_empty);
  assign in_fire   = bus.s_axis_tvalid && s_ready;
  assign sop       = (state_reg == ST_IDLE);
  assign fifo_pop  = in_fire && sop;
  assign fifo_push = bus.metadata_in_valid && (!fifo_full || fifo_pop);
  assign meta_drop = bus.metadata_in_valid && !fifo_push;

  assign keep_sum[0] = '0;
  for (genvar gi = 0; gi < AXIS_KEEP_WIDTH; gi++) begin : g_keep_pop
    assign keep_sum[gi+1] = keep_sum[gi] + 16'(bus.s_axis_tkeep[gi]);
  end

  // The SOP beat restarts the count and compares against the size it carries.
  assign byte_sum_next = (sop ? 16'd0 : byte_acc_reg) + keep_sum[AXIS_KEEP_WIDTH];
  assign size_ref      = sop ? bus.s_axis_tuser_size : m_size_reg;
  assign len_mismatch  = (byte_sum_next != 16'(size_ref));

  always_ff @(posedge axis_aclk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= bus.metadata_in;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_rstn) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      byte_acc_reg   <= '0;
      ovf_cnt_reg    <= '0;
      pkt_cnt_reg    <= '0;
      err_sticky_reg <= '0;
      m_valid_reg    <= 1'b0;
      m_last_reg     <= 1'b0;
      m_len_err_reg  <= 1'b0;
      m_data_reg     <= '0;
      m_keep_reg     <= '0;
      m_size_reg     <= '0;
      m_meta_reg     <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + {{PTR_W{1'b0}}, 1'b1};
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + {{PTR_W{1'b0}}, 1'b1};

      if (meta_drop) begin
        err_sticky_reg[0] <= 1'b1;
        if (ovf_cnt_reg != 16'hFFFF) ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
      end

      if (in_fire) begin
        m_valid_reg   <= 1'b1;
        m_data_reg    <= bus.s_axis_tdata;
        m_keep_reg    <= bus.s_axis_tkeep;
        m_last_reg    <= bus.s_axis_tlast;
        m_len_err_reg <= bus.s_axis_tlast && len_mismatch;
        byte_acc_reg  <= byte_sum_next;
        if (bus.s_axis_tlast && len_mismatch) err_sticky_reg[1] <= 1'b1;
        if (sop) begin
          m_size_reg <= bus.s_axis_tuser_size;
          m_meta_reg <= fifo_head;
        end
        state_reg <= bus.s_axis_tlast ? ST_IDLE : ST_IN_PKT;
      end else if (bus.m_axis_tready) begin
        m_valid_reg <= 1'b0;
      end

      if (m_valid_reg && bus.m_axis_tready && m_last_reg) begin
        pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.s_axis_tready         = s_ready;
  assign bus.m_axis_tvalid         = m_valid_reg;
  assign bus.m_axis_tdata          = m_data_reg;
  assign bus.m_axis_tkeep          = m_keep_reg;
  assign bus.m_axis_tlast          = m_last_reg;
  assign bus.m_axis_tuser_size     = m_size_reg;
  assign bus.m_axis_tuser_metadata = m_meta_reg;
  assign bus.m_axis_len_err        = m_len_err_reg;
  assign meta_overflow_cnt         = ovf_cnt_reg;
  assign pkt_cnt                   = pkt_cnt_reg;
  assign err_sticky                = err_sticky_reg;
endmodule
